// File: rtl/ser_pkg.sv
// Shared constants, types and helpers for the serial link.
// Used by the SIPO deserializer and its bit counter.
package ser_pkg;

  localparam int SER_WIDTH = 4;

  // Counter width for a modulo-n count; never below one bit.
  function automatic int clog2w(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

  typedef enum logic {
    O_EMPTY = 1'b0,
    O_FULL  = 1'b1
  } ostate_t;

endpackage

// File: rtl/ser_bit_counter.sv
// Modulo-WIDTH bit counter with strobe, sync clear and wrap pulse.
// Ports: clk, rst_n, ce, clr in; cnt (CNT_W), wrap out.
module ser_bit_counter
  import ser_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH,
  parameter int CNT_W = clog2w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             last;

  assign last = (cnt_q == LAST);

  // clr overrides ce, so an aborted bit never completes a word.
  assign wrap = ce && !clr && last;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (ce) begin
      if (last) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/sipo_deserializer.sv
// LSB-first serial-to-parallel deserializer with a one-entry
// valid/ready output register and a sticky overflow flag.
// Ports: clk, rst_n, ce, sin, clr, out_ready, ovf_clr in;
//        out_data (WIDTH), out_valid, bit_cnt (CNT_W), overflow out.
module sipo_deserializer
  import ser_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH,
  localparam int CNT_W = clog2w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             sin,
  input  logic             clr,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overflow,
  input  logic             ovf_clr
);

  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_d;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] out_data_q;
  logic [WIDTH-1:0] out_data_d;
  ostate_t          ost_q;
  ostate_t          ost_d;
  logic             ovf_q;
  logic             ovf_d;
  logic             wrap;
  logic             drop;

  ser_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .ce    (ce),
    .clr   (clr),
    .cnt   (bit_cnt),
    .wrap  (wrap)
  );

  // The completed word includes the bit sampled this cycle.
  assign word = {sin, sh_q[WIDTH-1:1]};

  always_comb begin
    sh_d = sh_q;
    if (clr) begin
      sh_d = '0;
    end else if (ce) begin
      sh_d = word;
    end
  end

  always_comb begin
    ost_d      = ost_q;
    out_data_d = out_data_q;
    drop       = 1'b0;
    unique case (ost_q)
      O_EMPTY: begin
        if (wrap) begin
          out_data_d = word;
          ost_d      = O_FULL;
        end
      end
      O_FULL: begin
        if (out_ready) begin
          if (wrap) begin
            out_data_d = word;
          end else begin
            ost_d = O_EMPTY;
          end
        end else if (wrap) begin
          drop = 1'b1;
        end
      end
      default: ost_d = O_EMPTY;
    endcase
  end

  // A drop in the same cycle as ovf_clr keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q       <= '0;
      out_data_q <= '0;
      ost_q      <= O_EMPTY;
      ovf_q      <= 1'b0;
    end else begin
      sh_q       <= sh_d;
      out_data_q <= out_data_d;
      ost_q      <= ost_d;
      ovf_q      <= ovf_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = (ost_q == O_FULL);
  assign overflow  = ovf_q;

endmodule
